// File: rtl/rename_phy_alloc_pkg.sv
// Shared configuration for the rename-stage physical register allocator:
// default sizes, derived widths and the free-list pointer type.
package rename_phy_alloc_pkg;

  localparam int RENAME_WIDTH_DEF   = 4;
  localparam int COMMIT_WIDTH_DEF   = 4;
  localparam int PHY_REG_NUM_DEF    = 64;
  localparam int ARCH_REG_NUM_DEF   = 32;
  localparam int CHECKPOINT_NUM_DEF = 8;

  localparam int PHY_REG_ID_WIDTH    = $clog2(PHY_REG_NUM_DEF);
  localparam int CHECKPOINT_ID_WIDTH = $clog2(CHECKPOINT_NUM_DEF);

  // MSB is the wrap bit: equal pointers mean empty, MSB-only difference means full.
  typedef logic [PHY_REG_ID_WIDTH:0] fl_ptr_t;

  typedef enum logic [1:0] {
    RPTR_HOLD,
    RPTR_ADVANCE,
    RPTR_RESTORE,
    RPTR_FLUSH
  } rptr_sel_e;

endpackage

// File: rtl/rename_phy_alloc_popcount_prefix.sv
// Exclusive prefix popcount: prefix_o[i] counts set bits below i, total_o counts all.
module rename_phy_alloc_popcount_prefix #(
  parameter  int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0]            bits_i,
  output logic [WIDTH-1:0][CNT_W-1:0] prefix_o,
  output logic [CNT_W-1:0]            total_o
);

  always_comb begin
    logic [CNT_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      prefix_o[i] = acc;
      acc = acc + CNT_W'(bits_i[i]);
    end
    total_o = acc;
  end

endmodule

// File: rtl/rename_phy_alloc.sv
// Free-list allocator for rename: circular FIFO of physical IDs with speculative,
// committed and tail pointers, per-channel compacted grants and checkpoint rollback.
module rename_phy_alloc
  import rename_phy_alloc_pkg::*;
#(
  parameter  int RENAME_WIDTH   = RENAME_WIDTH_DEF,
  parameter  int COMMIT_WIDTH   = COMMIT_WIDTH_DEF,
  parameter  int PHY_REG_NUM    = PHY_REG_NUM_DEF,
  parameter  int ARCH_REG_NUM   = ARCH_REG_NUM_DEF,
  parameter  int CHECKPOINT_NUM = CHECKPOINT_NUM_DEF,
  parameter  int ALLOC_MODE     = 0,
  localparam int ID_W   = $clog2(PHY_REG_NUM),
  localparam int PTR_W  = ID_W + 1,
  localparam int CP_W   = $clog2(CHECKPOINT_NUM),
  localparam int RCNT_W = $clog2(RENAME_WIDTH + 1),
  localparam int CCNT_W = $clog2(COMMIT_WIDTH + 1),
  localparam int CH_W   = ($clog2(RENAME_WIDTH) > 0) ? $clog2(RENAME_WIDTH) : 1
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [RENAME_WIDTH-1:0]            req_need_i,
  output logic [RENAME_WIDTH-1:0][ID_W-1:0]  alloc_phy_id_o,
  output logic [RENAME_WIDTH-1:0]            alloc_valid_o,
  input  logic                               alloc_accept_i,
  input  logic [COMMIT_WIDTH-1:0][ID_W-1:0]  release_phy_id_i,
  input  logic [COMMIT_WIDTH-1:0]            release_valid_i,
  input  logic [RCNT_W-1:0]                  commit_alloc_num_i,
  input  logic                               cp_save_we_i,
  input  logic [CP_W-1:0]                    cp_save_id_i,
  input  logic [CH_W-1:0]                    cp_save_channel_i,
  input  logic                               cp_restore_i,
  input  logic [CP_W-1:0]                    cp_restore_id_i,
  input  logic                               flush_i,
  output logic [PTR_W-1:0]                   free_count_o,
  output logic                               alloc_stall_add_o
);

  logic [ID_W-1:0]  fl_q [PHY_REG_NUM];
  logic [PTR_W-1:0] cp_rptr_q [CHECKPOINT_NUM];
  logic [PTR_W-1:0] rptr_q, rptr_d, crptr_q, crptr_d, wptr_q, wptr_d;

  logic [RENAME_WIDTH-1:0][RCNT_W-1:0] req_k;
  logic [RCNT_W-1:0]                   req_total;
  logic [COMMIT_WIDTH-1:0][CCNT_W-1:0] rel_k;
  logic [CCNT_W-1:0]                   rel_total;
  logic [ID_W-1:0]                     rd_idx [RENAME_WIDTH];
  logic [ID_W-1:0]                     wr_idx [COMMIT_WIDTH];

  logic [PTR_W-1:0]        free_cnt;
  logic [RENAME_WIDTH-1:0] grant_raw;
  logic                    group_short;
  logic [RCNT_W-1:0]       grant_cnt, save_cnt;
  logic                    cp_take;
  rptr_sel_e               rptr_sel;

  rename_phy_alloc_popcount_prefix #(.WIDTH(RENAME_WIDTH)) u_req_prefix (
    .bits_i   (req_need_i),
    .prefix_o (req_k),
    .total_o  (req_total)
  );

  rename_phy_alloc_popcount_prefix #(.WIDTH(COMMIT_WIDTH)) u_rel_prefix (
    .bits_i   (release_valid_i),
    .prefix_o (rel_k),
    .total_o  (rel_total)
  );

  assign free_cnt     = wptr_q - rptr_q;
  assign free_count_o = free_cnt;

  for (genvar gi = 0; gi < RENAME_WIDTH; gi++) begin : g_rd
    assign rd_idx[gi]         = rptr_q[ID_W-1:0] + ID_W'(req_k[gi]);
    assign alloc_phy_id_o[gi] = fl_q[rd_idx[gi]];
    assign grant_raw[gi]      = req_need_i[gi] && (PTR_W'(req_k[gi]) < free_cnt);
  end

  for (genvar gi = 0; gi < COMMIT_WIDTH; gi++) begin : g_wr
    assign wr_idx[gi] = wptr_q[ID_W-1:0] + ID_W'(rel_k[gi]);
  end

  // Group mode: a single needing channel without an entry blocks the whole group.
  assign group_short   = PTR_W'(req_total) > free_cnt;
  assign alloc_valid_o = (ALLOC_MODE == 1 && group_short) ? '0 : grant_raw;
  assign alloc_stall_add_o = |(req_need_i & ~alloc_valid_o);

  always_comb begin
    grant_cnt = '0;
    save_cnt  = '0;
    for (int i = 0; i < RENAME_WIDTH; i++) begin
      if (alloc_valid_o[i]) begin
        grant_cnt = grant_cnt + RCNT_W'(1);
        if (CH_W'(i) <= cp_save_channel_i) save_cnt = save_cnt + RCNT_W'(1);
      end
    end
  end

  always_comb begin
    if (flush_i)             rptr_sel = RPTR_FLUSH;
    else if (cp_restore_i)   rptr_sel = RPTR_RESTORE;
    else if (alloc_accept_i) rptr_sel = RPTR_ADVANCE;
    else                     rptr_sel = RPTR_HOLD;
  end

  always_comb begin
    crptr_d = crptr_q + PTR_W'(commit_alloc_num_i);
    wptr_d  = wptr_q + PTR_W'(rel_total);
    case (rptr_sel)
      RPTR_FLUSH:   rptr_d = crptr_q + PTR_W'(commit_alloc_num_i);
      RPTR_RESTORE: rptr_d = cp_rptr_q[cp_restore_id_i];
      RPTR_ADVANCE: rptr_d = rptr_q + PTR_W'(grant_cnt);
      default:      rptr_d = rptr_q;
    endcase
  end

  // A snapshot only records a head that is actually being advanced this cycle.
  assign cp_take = cp_save_we_i && (rptr_sel == RPTR_ADVANCE);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rptr_q  <= '0;
      crptr_q <= '0;
      wptr_q  <= PTR_W'(PHY_REG_NUM - ARCH_REG_NUM);
      for (int n = 0; n < PHY_REG_NUM; n++) begin
        fl_q[n] <= (n < PHY_REG_NUM - ARCH_REG_NUM) ? ID_W'(ARCH_REG_NUM + n) : '0;
      end
      for (int c = 0; c < CHECKPOINT_NUM; c++) begin
        cp_rptr_q[c] <= '0;
      end
    end else begin
      rptr_q  <= rptr_d;
      crptr_q <= crptr_d;
      wptr_q  <= wptr_d;
      for (int s = 0; s < COMMIT_WIDTH; s++) begin
        if (release_valid_i[s]) fl_q[wr_idx[s]] <= release_phy_id_i[s];
      end
      if (cp_take) cp_rptr_q[cp_save_id_i] <= rptr_q + PTR_W'(save_cnt);
    end
  end

  logic [PTR_W-1:0] occupancy;
  assign occupancy = wptr_q - crptr_q;

  a_no_overfill: assert property (@(posedge clk_i) disable iff (!rst_ni)
    occupancy <= PTR_W'(PHY_REG_NUM));

endmodule

// File: tb/tb_rename_phy_alloc.sv
// Random + directed bench for rename_phy_alloc; mode 0 and mode 1 instances share stimulus
// and are compared against an unbounded-integer free-list model.
module tb_rename_phy_alloc;

  localparam int RW = 4, CW = 4, PN = 64, AN = 32, CN = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [RW-1:0]       req_need;
  logic                accept;
  logic [CW-1:0][5:0]  rel_id;
  logic [CW-1:0]       rel_valid;
  logic [2:0]          commit_n;
  logic                save_we;
  logic [2:0]          save_id;
  logic [1:0]          save_ch;
  logic                restore;
  logic [2:0]          restore_id;
  logic                flush;

  logic [RW-1:0][5:0]  id0, id1;
  logic [RW-1:0]       valid0, valid1;
  logic [6:0]          free0, free1;
  logic                stall0, stall1;

  rename_phy_alloc #(.ALLOC_MODE(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .req_need_i(req_need), .alloc_phy_id_o(id0),
    .alloc_valid_o(valid0), .alloc_accept_i(accept), .release_phy_id_i(rel_id),
    .release_valid_i(rel_valid), .commit_alloc_num_i(commit_n), .cp_save_we_i(save_we),
    .cp_save_id_i(save_id), .cp_save_channel_i(save_ch), .cp_restore_i(restore),
    .cp_restore_id_i(restore_id), .flush_i(flush), .free_count_o(free0),
    .alloc_stall_add_o(stall0)
  );

  rename_phy_alloc #(.ALLOC_MODE(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .req_need_i(req_need), .alloc_phy_id_o(id1),
    .alloc_valid_o(valid1), .alloc_accept_i(accept), .release_phy_id_i(rel_id),
    .release_valid_i(rel_valid), .commit_alloc_num_i(commit_n), .cp_save_we_i(save_we),
    .cp_save_id_i(save_id), .cp_save_channel_i(save_ch), .cp_restore_i(restore),
    .cp_restore_id_i(restore_id), .flush_i(flush), .free_count_o(free1),
    .alloc_stall_add_o(stall1)
  );

  // Reference model: plain integer pointers that never wrap, list indexed modulo PN.
  int fl_m [2][PN];
  int rd [2], crd [2], wr [2];
  int cp_m [2][CN];
  int live [$];
  logic [RW-1:0] last_v [2];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic model_out(input int m, output logic [RW-1:0] v,
                           output logic [RW-1:0][5:0] ids, output logic stall);
    int k, free;
    bit short_grp;
    k = 0; free = wr[m] - rd[m]; short_grp = 0;
    v = '0; ids = '0;
    for (int i = 0; i < RW; i++) begin
      if (req_need[i]) begin
        ids[i] = 6'(fl_m[m][(rd[m] + k) % PN]);
        if (k < free) v[i] = 1'b1;
        else short_grp = 1;
        k++;
      end
    end
    if (m == 1 && short_grp) v = '0;
    stall = |(req_need & ~v);
  endtask

  task automatic model_update();
    int c, old_crd, snap;
    if (!rst_n) begin
      live.delete();
      for (int a = 0; a < AN; a++) live.push_back(a);
      for (int m = 0; m < 2; m++) begin
        rd[m] = 0; crd[m] = 0; wr[m] = PN - AN;
        for (int n = 0; n < PN; n++) fl_m[m][n] = (n < PN - AN) ? AN + n : 0;
        for (int s = 0; s < CN; s++) cp_m[m][s] = 0;
      end
      return;
    end
    for (int j = 0; j < int'(commit_n); j++) live.push_back(fl_m[0][(crd[0] + j) % PN]);
    for (int m = 0; m < 2; m++) begin
      c = 0;
      for (int s = 0; s < CW; s++) begin
        if (rel_valid[s]) begin
          fl_m[m][(wr[m] + c) % PN] = int'(rel_id[s]);
          c++;
        end
      end
      wr[m] += c;
      old_crd = crd[m];
      crd[m] += int'(commit_n);
      if (flush) rd[m] = old_crd + int'(commit_n);
      else if (restore) rd[m] = cp_m[m][restore_id];
      else if (accept) begin
        if (save_we) begin
          snap = rd[m];
          for (int i = 0; i <= int'(save_ch); i++) if (last_v[m][i]) snap++;
          cp_m[m][save_id] = snap;
        end
        rd[m] += $countones(last_v[m]);
      end
    end
  endtask

  task automatic step();
    logic [RW-1:0] ev, dv;
    logic [RW-1:0][5:0] eid, did;
    logic es, ds;
    logic [6:0] df;
    bit in_live;
    @(negedge clk);
    if (rst_n) begin
      for (int m = 0; m < 2; m++) begin
        model_out(m, ev, eid, es);
        last_v[m] = ev;
        dv  = (m == 0) ? valid0 : valid1;
        did = (m == 0) ? id0 : id1;
        ds  = (m == 0) ? stall0 : stall1;
        df  = (m == 0) ? free0 : free1;
        check_eq($sformatf("m%0d_valid", m), 64'(dv), 64'(ev));
        check_eq($sformatf("m%0d_free", m), 64'(df), 64'(wr[m] - rd[m]));
        check_eq($sformatf("m%0d_stall", m), 64'(ds), 64'(es));
        for (int i = 0; i < RW; i++) begin
          if (ev[i]) begin
            check_eq($sformatf("m%0d_id%0d", m, i), 64'(did[i]), 64'(eid[i]));
            if (m == 0) begin
              in_live = 0;
              foreach (live[q]) if (live[q] == int'(did[i])) in_live = 1;
              check_eq($sformatf("dup_id%0d", i), 64'(in_live), 64'd0);
            end
          end
        end
      end
      $display("[TB] t=%0t req=%b acc=%b fl=%b rs=%b v0=%b v1=%b free0=%0d free1=%0d",
               $time, req_need, accept, flush, restore, valid0, valid1, free0, free1);
    end
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    req_need = '0; accept = 0; rel_id = '0; rel_valid = '0; commit_n = '0;
    save_we = 0; save_id = '0; save_ch = '0; restore = 0; restore_id = '0; flush = 0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    step();
    step();
    rst_n = 1;
  endtask

  task automatic set_release(input int n);
    rel_valid = '0;
    while ($countones(rel_valid) < n) rel_valid[$urandom_range(0, CW - 1)] = 1'b1;
    for (int s = 0; s < CW; s++) rel_id[s] = rel_valid[s] ? 6'(live.pop_front()) : 6'($urandom);
  endtask

  function automatic bit cp_ok(input int id, input int n);
    bit ok = 1;
    for (int m = 0; m < 2; m++)
      if (cp_m[m][id] < crd[m] + n || cp_m[m][id] > rd[m]) ok = 0;
    return ok;
  endfunction

  task automatic drive_random();
    int n, spec;
    req_need = 4'($urandom);
    accept   = ($urandom % 4) != 0;
    spec = rd[0] - crd[0];
    if (rd[1] - crd[1] < spec) spec = rd[1] - crd[1];
    n = $urandom_range(0, 4);
    if (n > spec) n = spec;
    commit_n = 3'(n);
    set_release(n);
    flush = ($urandom % 30) == 0;
    restore_id = 3'($urandom);
    restore = !flush && (($urandom % 10) == 0) && cp_ok(int'(restore_id), n);
    save_we = ($urandom % 3) == 0;
    save_id = 3'($urandom);
    save_ch = 2'($urandom);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Full-width grant straight out of reset.
    do_reset();
    req_need = 4'b1111; accept = 1; #1;
    for (int i = 0; i < RW; i++) check_eq($sformatf("rst_id%0d", i), 64'(id0[i]), 64'(32 + i));
    check_eq("rst_valid", 64'(valid0), 64'hF);
    step(); idle(); #1;
    check_eq("free_after4", 64'(free0), 64'd28);

    // Sparse request compaction.
    do_reset();
    req_need = 4'b1010; accept = 1; #1;
    check_eq("cmp_id1", 64'(id0[1]), 64'd32);
    check_eq("cmp_id3", 64'(id0[3]), 64'd33);
    check_eq("cmp_valid", 64'(valid0), 64'b1010);
    step(); idle(); #1;
    check_eq("cmp_free", 64'(free0), 64'd30);

    // Drain to two free entries; partial vs group grant.
    do_reset();
    req_need = 4'b1111; accept = 1;
    repeat (7) step();
    req_need = 4'b0011;
    step();
    req_need = 4'b0111; accept = 0; #1;
    check_eq("m0_short_valid", 64'(valid0), 64'b0011);
    check_eq("m0_short_stall", 64'(stall0), 64'd1);
    check_eq("m1_short_valid", 64'(valid1), 64'd0);
    check_eq("m1_short_stall", 64'(stall1), 64'd1);
    accept = 1;
    step(); idle(); #1;
    check_eq("m0_drained", 64'(free0), 64'd0);
    check_eq("m1_held", 64'(free1), 64'd2);

    // Checkpoint after channel 1, allocate past it, then roll back.
    do_reset();
    req_need = 4'b1111; accept = 1; save_we = 1; save_id = 3'd3; save_ch = 2'd1;
    step();
    save_we = 0;
    step(); step();
    restore = 1; restore_id = 3'd3;
    step(); idle();
    req_need = 4'b0001; #1;
    check_eq("restore_id0", 64'(id0[0]), 64'd34);
    step(); idle();

    // Release and flush in the same cycle.
    do_reset();
    req_need = 4'b1111; accept = 1;
    step(); step(); idle();
    commit_n = 3'd4; set_release(4);
    step(); idle(); #1;
    check_eq("pre_flush_free", 64'(free0), 64'd28);
    commit_n = 3'd2; set_release(4); flush = 1;
    step(); idle(); #1;
    check_eq("flush_free", 64'(free0), 64'd34);
    req_need = 4'b0001; #1;
    check_eq("flush_id0", 64'(id0[0]), 64'd38);
    step(); idle();

    // Random traffic through several pointer wraps.
    do_reset();
    repeat (220) begin
      drive_random();
      step();
    end
    idle();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
